// File: rtl/i2c_reg_seq_pkg.sv
// Shared i2c definitions: master command bits, status bits, result codes,
// plus the sequencer state type and the per-step command builder.
package i2c_reg_seq_pkg;

   localparam int C_SZ = 6;
   localparam logic [C_SZ-1:0] C_STRT = 6'b000001;
   localparam logic [C_SZ-1:0] C_STOP = 6'b000010;
   localparam logic [C_SZ-1:0] C_READ = 6'b000100;
   localparam logic [C_SZ-1:0] C_WRTE = 6'b001000;
   localparam logic [C_SZ-1:0] C_NACK = 6'b010000;
   localparam logic [C_SZ-1:0] C_CLRS = 6'b100000;

   localparam int S_SZ   = 2;
   localparam int SB_BSY = 0;
   localparam int SB_ERR = 1;

   localparam logic [1:0] ERR_OK  = 2'd0;
   localparam logic [1:0] ERR_NAK = 2'd1;
   localparam logic [1:0] ERR_TMO = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BSY,
      ST_WAIT_DONE,
      ST_CLR,
      ST_ABORT_STOP,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [C_SZ-1:0] cmd;
      logic [7:0]      dat;
   } mst_word_t;

   // Step 2 differs between write (data + STOP) and read (repeated START).
   function automatic mst_word_t seq_word(input logic [1:0] step,
                                          input logic       rnw,
                                          input logic [6:0] dev,
                                          input logic [7:0] reg_adr,
                                          input logic [7:0] wdat);
      mst_word_t w;
      case (step)
         2'd0: begin
            w.cmd = C_STRT | C_WRTE;
            w.dat = {dev, 1'b0};
         end
         2'd1: begin
            w.cmd = C_WRTE;
            w.dat = reg_adr;
         end
         2'd2: begin
            if (rnw) begin
               w.cmd = C_STRT | C_WRTE;
               w.dat = {dev, 1'b1};
            end else begin
               w.cmd = C_WRTE | C_STOP;
               w.dat = wdat;
            end
         end
         default: begin
            w.cmd = C_READ | C_NACK | C_STOP;
            w.dat = 8'h00;
         end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// Host request side and i2c_master command side of the register sequencer.
interface i2c_reg_seq_if;
   import i2c_reg_seq_pkg::*;

   // req is a one-cycle strobe taken only while idle (busy=0, done=0);
   // the result (err, rdat) is valid in the single cycle done is high.
   // Toward the master, mst_ws strobes mst_cmd/mst_dat; completion is read
   // back from mst_stat[SB_BSY] / mst_stat[SB_ERR].
   logic            req;
   logic            rnw;
   logic [6:0]      dev;
   logic [7:0]      reg_adr;
   logic [7:0]      wdat;
   logic            busy;
   logic            done;
   logic [1:0]      err;
   logic [7:0]      rdat;
   logic [C_SZ-1:0] mst_cmd;
   logic [7:0]      mst_dat;
   logic            mst_ws;
   logic [S_SZ-1:0] mst_stat;
   logic [7:0]      mst_din;
   state_t          dbg_state;

   modport slave (
      input  req, rnw, dev, reg_adr, wdat, mst_stat, mst_din,
      output busy, done, err, rdat, mst_cmd, mst_dat, mst_ws, dbg_state
   );

   modport master (
      output req, rnw, dev, reg_adr, wdat, mst_stat, mst_din,
      input  busy, done, err, rdat, mst_cmd, mst_dat, mst_ws, dbg_state
   );

endinterface

// File: rtl/i2c_seq_tmo.sv
// Per-command watchdog: counts cycles since the command was issued and
// flags the cycle after which TMO cycles will have elapsed.
module i2c_seq_tmo #(
   parameter int TMO = 65535,
   parameter int TW  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TW-1:0] cnt_q, cnt_d;

   // The issue cycle itself is cycle 0, so the abort lands exactly TMO
   // cycles after the command strobe.
   assign expired = (cnt_q == TW'(TMO - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register read/write sequencer driving an i2c_master one byte command at a
// time, with error clean-up (CLRS + STOP) and a per-command timeout.
module i2c_reg_seq
   import i2c_reg_seq_pkg::*;
#(
   parameter int TMO = 65535,
   parameter int TW  = 16
) (
   input logic          clk,
   input logic          rst,
   i2c_reg_seq_if.slave bus
);

   state_t          state_q, state_d;
   logic [1:0]      step_q, step_d;
   logic            rnw_q, rnw_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_adr_q, reg_adr_d;
   logic [7:0]      wdat_q, wdat_d;
   logic [1:0]      err_q, err_d;
   logic [7:0]      rdat_q, rdat_d;
   logic [C_SZ-1:0] cmd_q, cmd_d;
   logic [7:0]      dat_q, dat_d;
   logic            abort_q, abort_d;
   logic            tmo_clr, tmo_en, tmo_expired;
   logic            m_bsy, m_err;
   mst_word_t       first_w, next_w;

   assign m_bsy   = bus.mst_stat[SB_BSY];
   assign m_err   = bus.mst_stat[SB_ERR];
   assign first_w = seq_word(2'd0, bus.rnw, bus.dev, bus.reg_adr, bus.wdat);
   assign next_w  = seq_word(step_q + 2'd1, rnw_q, dev_q, reg_adr_q, wdat_q);
   assign tmo_en  = (state_q == ST_ISSUE) || (state_q == ST_ABORT_STOP) ||
                    (state_q == ST_WAIT_BSY) || (state_q == ST_WAIT_DONE);

   i2c_seq_tmo #(.TMO(TMO), .TW(TW)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      rnw_d     = rnw_q;
      dev_d     = dev_q;
      reg_adr_d = reg_adr_q;
      wdat_d    = wdat_q;
      err_d     = err_q;
      rdat_d    = rdat_q;
      cmd_d     = cmd_q;
      dat_d     = dat_q;
      abort_d   = abort_q;
      tmo_clr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               rnw_d     = bus.rnw;
               dev_d     = bus.dev;
               reg_adr_d = bus.reg_adr;
               wdat_d    = bus.wdat;
               step_d    = 2'd0;
               err_d     = ERR_OK;
               abort_d   = 1'b0;
               cmd_d     = first_w.cmd;
               dat_d     = first_w.dat;
               tmo_clr   = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE:      state_d = ST_WAIT_BSY;
         ST_ABORT_STOP: state_d = ST_WAIT_BSY;
         ST_WAIT_BSY, ST_WAIT_DONE: begin
            // Master error outranks a coincident timeout; while finishing
            // the abort STOP any failure just ends the transaction.
            if (m_err || tmo_expired) begin
               if (abort_q) begin
                  state_d = ST_DONE;
               end else begin
                  err_d   = m_err ? ERR_NAK : ERR_TMO;
                  cmd_d   = C_CLRS;
                  dat_d   = 8'h00;
                  state_d = ST_CLR;
               end
            end else if (state_q == ST_WAIT_BSY) begin
               if (m_bsy) state_d = ST_WAIT_DONE;
            end else if (!m_bsy) begin
               if (abort_q) begin
                  state_d = ST_DONE;
               end else if (step_q == (rnw_q ? 2'd3 : 2'd2)) begin
                  if (rnw_q) rdat_d = bus.mst_din;
                  state_d = ST_DONE;
               end else begin
                  step_d  = step_q + 2'd1;
                  cmd_d   = next_w.cmd;
                  dat_d   = next_w.dat;
                  tmo_clr = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_CLR: begin
            if (err_q == ERR_NAK) begin
               cmd_d   = C_STOP;
               dat_d   = 8'h00;
               abort_d = 1'b1;
               tmo_clr = 1'b1;
               state_d = ST_ABORT_STOP;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         step_q    <= 2'd0;
         rnw_q     <= 1'b0;
         dev_q     <= 7'h00;
         reg_adr_q <= 8'h00;
         wdat_q    <= 8'h00;
         err_q     <= ERR_OK;
         rdat_q    <= 8'h00;
         cmd_q     <= '0;
         dat_q     <= 8'h00;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         rnw_q     <= rnw_d;
         dev_q     <= dev_d;
         reg_adr_q <= reg_adr_d;
         wdat_q    <= wdat_d;
         err_q     <= err_d;
         rdat_q    <= rdat_d;
         cmd_q     <= cmd_d;
         dat_q     <= dat_d;
         abort_q   <= abort_d;
      end
   end

   assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = err_q;
   assign bus.rdat      = rdat_q;
   assign bus.mst_cmd   = cmd_q;
   assign bus.mst_dat   = dat_q;
   assign bus.mst_ws    = (state_q == ST_ISSUE) || (state_q == ST_CLR) ||
                          (state_q == ST_ABORT_STOP);
   assign bus.dbg_state = state_q;

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter TMO, default 65535: cycles allowed per master command before a timeout abort.
REQ-002 Parameter TW, default 16: timeout counter width; TMO SHALL fit in TW bits.
REQ-003 clk  in  1  single clock; all state SHALL change on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  one-cycle request strobe, sampled only in IDLE.
REQ-006 rnw  in  1  1=register read, 0=register write; sampled with req.
REQ-007 dev  in  7  7-bit device address; sampled with req.
REQ-008 reg_adr  in  8  register address; sampled with req.
REQ-009 wdat  in  8  write data; sampled with req.
REQ-010 busy  out  1  high from the cycle after req is accepted until done.
REQ-011 done  out  1  one-cycle pulse at the end of a transaction.
REQ-012 err  out  2  transaction result, valid with done (0=ok, 1=master error/NAK, 2=timeout).
REQ-013 rdat  out  8  read data, valid with done when rnw=1 and err=0; held until the next done.
REQ-014 mst_cmd  out  C_SZ  command word to i2c_master.
REQ-015 mst_dat  out  8  data byte to i2c_master.
REQ-016 mst_ws  out  1  one-cycle write strobe to i2c_master.
REQ-017 mst_stat  in  S_SZ  i2c_master status; uses SB_BSY and SB_ERR.
REQ-018 mst_din  in  8  i2c_master received byte.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_BSY, WAIT_DONE, CLR, ABORT_STOP, DONE.
REQ-020 Write sequence SHALL be: step 0 STRT|WRTE with dat={dev,0}; step 1 WRTE with dat=reg_adr; step 2 WRTE|STOP with dat=wdat.
REQ-021 Read sequence SHALL be: step 0 STRT|WRTE with {dev,0}; step 1 WRTE with reg_adr; step 2 STRT|WRTE with {dev,1}; step 3 READ|NACK|STOP.
REQ-022 ISSUE SHALL drive mst_cmd/mst_dat and pulse mst_ws for exactly one cycle, then go to WAIT_BSY; mst_cmd/mst_dat SHALL stay stable until the next ISSUE or CLR.
REQ-023 WAIT_BSY: on SB_ERR go to CLR; on SB_BSY=1 go to WAIT_DONE; otherwise remain.
REQ-024 WAIT_DONE: on SB_BSY=0 with SB_ERR=0, advance the step (ISSUE) or, after the last step, go to DONE; on SB_ERR go to CLR.
REQ-025 On completion of read step 3, rdat SHALL latch mst_din.
REQ-026 The timeout counter SHALL clear at each ISSUE and increment in WAIT_BSY and WAIT_DONE; reaching TMO SHALL set err=2 and go to CLR.
REQ-027 CLR SHALL pulse mst_ws with C_CLRS for one cycle. After a master error the FSM SHALL next issue C_STOP (ABORT_STOP, waiting on busy as in ISSUE), then go to DONE with err=1. After a timeout it SHALL go directly to DONE with err=2.
REQ-028 An SB_ERR or timeout during ABORT_STOP SHALL go to DONE with err unchanged; no second CLRS.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE; busy SHALL fall in the same cycle.
REQ-030 req outside IDLE SHALL be ignored. The earliest accepted req is one cycle after done.
REQ-031 SB_ERR and the timeout in the same cycle: the master error SHALL win (err=1).

Reset
REQ-032 On rst: state=IDLE, step=0, counter=0, busy=0, done=0, err=0, rdat=0, mst_ws=0, mst_cmd=0, mst_dat=0.
REQ-033 rst mid-transaction SHALL abort silently, with no done pulse and no STOP issued.

Structure
REQ-034 C_* command bits, SB_* status bits, C_SZ and S_SZ SHALL live in a shared i2c define include used by i2c_master, i2c_slave and this block.
REQ-035 The err code values SHALL be defined in that same include.
REQ-036 The timeout counter SHALL be a sub-module i2c_seq_tmo (clear, enable, TMO compare, expired output).

Verification
REQ-037 Write: dev=0x3b, reg_adr=0x10, wdat=0xa5 with the slave attached -> three mst_ws pulses with dat 0x76, 0x10, 0xa5; slave receives 0xa5; done with err=0.
REQ-038 Read: dev=0x3b, reg_adr=0x10, slave preloaded 0x55 -> mst_dat 0x76, 0x10, 0x77, then READ|NACK|STOP; rdat=0x55; err=0.
REQ-039 NAK: dev=0x12, no slave at that address -> CLRS then STOP issued; done with err=1; bus idle (sda=scl=1) afterwards.
REQ-040 Timeout: TMO=50, stub master holds SB_BSY=1 -> CLRS issued 50 cycles after ISSUE; done with err=2; no STOP.
REQ-041 Back-to-back: req held high during a transaction -> only one transaction runs; a req one cycle after done is accepted.
REQ-042 Reset: rst asserted during read step 2 -> all outputs at reset values within the same cycle; no done pulse.
